// File: rtl/fpga_template_pkg.sv
// Shared sample types and defaults for the audio capture path.
package fpga_template_pkg;

   localparam int SAMPLE_W                 = 24;
   localparam int SAMPLE_BUF_DEPTH_DEFAULT = 1024;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sample_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port, single clock.
module sample_ram_sdp #(
   parameter int DEPTH  = 1024,
   parameter int WIDTH  = 24,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: no reset on the array or the read register, so this maps onto block RAM.
   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/sample_ram_buffer.sv
// One-channel sample ring buffer with a first-word-fall-through read port.
// Define SAMPLE_RAM_BUFFER_DROP_CNT_EN to add the saturating drop_cnt_o counter.
module sample_ram_buffer
   import fpga_template_pkg::*;
#(
   parameter int   DEPTH       = SAMPLE_BUF_DEPTH_DEFAULT,
   parameter int   READY_LEVEL = 256,
   parameter logic SELECT_LEFT = 1'b1
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic                         sample_valid_i,
   input  logic signed [SAMPLE_W-1:0]   left_sample_i,
   input  logic signed [SAMPLE_W-1:0]   right_sample_i,
   output logic signed [SAMPLE_W-1:0]   rd_data_o,
   output logic                         rd_valid_o,
   input  logic                         rd_ready_i,
   output logic                         buffer_ready_o,
   output logic [$clog2(DEPTH+1)-1:0]   fill_o,
   output logic                         overflow_o
`ifdef SAMPLE_RAM_BUFFER_DROP_CNT_EN
   ,
   output logic [15:0]                  drop_cnt_o
`endif
);

   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = $clog2(DEPTH + 1);
   localparam logic [FILL_W-1:0] FULL_LVL  = FILL_W'(DEPTH);
   localparam logic [FILL_W-1:0] READY_LVL = FILL_W'(READY_LEVEL);

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [FILL_W-1:0] ram_level;
   logic [FILL_W-1:0] ram_level_nxt;
   logic [FILL_W-1:0] fill_nxt;
   logic              pf_valid;
   logic              full;
   logic              pop;
   logic              push;
   logic              drop;
   logic              out_load;
   logic              re;
   logic              flush;
   sample_t           wr_sample;
   sample_t           ram_rdata;

   assign flush     = rst_i | clear_i;
   assign wr_sample = SELECT_LEFT ? left_sample_i : right_sample_i;
   assign full      = (fill_o == FULL_LVL);
   assign pop       = rd_valid_o & rd_ready_i;
   assign push      = sample_valid_i & (~full | pop);
   assign drop      = sample_valid_i & full & ~pop;

   // ram_level counts words in RAM not yet issued to the read port; pf_valid
   // marks a word sitting in the RAM read register waiting for the output slot.
   assign out_load      = pf_valid & (~rd_valid_o | pop);
   assign re            = (ram_level != '0) & (~pf_valid | out_load);
   assign ram_level_nxt = ram_level + FILL_W'(push) - FILL_W'(re);

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      fill_nxt = fill_o;
      if (push && !pop)      fill_nxt = fill_o + FILL_W'(1);
      else if (pop && !push) fill_nxt = fill_o - FILL_W'(1);
   end

   sample_ram_sdp #(
      .DEPTH (DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_ram (
      .clk_i   (clk_i),
      .we_i    (push & ~flush),
      .waddr_i (wr_ptr),
      .wdata_i (wr_sample),
      .re_i    (re & ~flush),
      .raddr_i (rd_ptr),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (flush) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         ram_level      <= '0;
         pf_valid       <= 1'b0;
         rd_valid_o     <= 1'b0;
         rd_data_o      <= '0;
         fill_o         <= '0;
         buffer_ready_o <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (re)   rd_ptr <= rd_ptr + PTR_W'(1);
         ram_level <= ram_level_nxt;

         if (re)            pf_valid <= 1'b1;
         else if (out_load) pf_valid <= 1'b0;

         if (out_load) begin
            rd_valid_o <= 1'b1;
            rd_data_o  <= ram_rdata;
         end else if (pop) begin
            rd_valid_o <= 1'b0;
         end

         fill_o <= fill_nxt;

         // Hysteresis: set at the threshold, cleared only once drained.
         if (fill_nxt >= READY_LVL) buffer_ready_o <= 1'b1;
         else if (fill_nxt == '0)   buffer_ready_o <= 1'b0;
      end
   end

`ifdef SAMPLE_RAM_BUFFER_DROP_CNT_EN
   always_ff @(posedge clk_i) begin
      if (flush)                             drop_cnt_o <= '0;
      else if (drop && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
   end

   assign overflow_o = (drop_cnt_o != 16'd0);
`else
   always_ff @(posedge clk_i) begin
      if (flush)     overflow_o <= 1'b0;
      else if (drop) overflow_o <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_sample_ram_buffer.sv
// Directed bench for sample_ram_buffer: one left-channel and one right-channel instance, DEPTH=8.
module tb_sample_ram_buffer;

   logic        clk = 1'b0;
   logic        rst, clear, sample_valid, rd_ready;
   logic [23:0] left, right;
   logic [23:0] rd_data, rd_data_r;
   logic        rd_valid, rd_valid_r;
   logic        buffer_ready, buffer_ready_r;
   logic        overflow, overflow_r;
   logic [3:0]  fill, fill_r;
`ifdef SAMPLE_RAM_BUFFER_DROP_CNT_EN
   logic [15:0] drop_cnt, drop_cnt_r;
`endif

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   logic [23:0] got_l[$];
   logic [23:0] got_r[$];
   int          cyc_r[$];

   always #5 clk = ~clk;

   sample_ram_buffer #(.DEPTH(8), .READY_LEVEL(4), .SELECT_LEFT(1'b1)) u_dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .clear_i        (clear),
      .sample_valid_i (sample_valid),
      .left_sample_i  (left),
      .right_sample_i (right),
      .rd_data_o      (rd_data),
      .rd_valid_o     (rd_valid),
      .rd_ready_i     (rd_ready),
      .buffer_ready_o (buffer_ready),
      .fill_o         (fill),
      .overflow_o     (overflow)
`ifdef SAMPLE_RAM_BUFFER_DROP_CNT_EN
      ,
      .drop_cnt_o     (drop_cnt)
`endif
   );

   sample_ram_buffer #(.DEPTH(8), .READY_LEVEL(4), .SELECT_LEFT(1'b0)) u_dut_r (
      .clk_i          (clk),
      .rst_i          (rst),
      .clear_i        (clear),
      .sample_valid_i (sample_valid),
      .left_sample_i  (left),
      .right_sample_i (right),
      .rd_data_o      (rd_data_r),
      .rd_valid_o     (rd_valid_r),
      .rd_ready_i     (rd_ready),
      .buffer_ready_o (buffer_ready_r),
      .fill_o         (fill_r),
      .overflow_o     (overflow_r)
`ifdef SAMPLE_RAM_BUFFER_DROP_CNT_EN
      ,
      .drop_cnt_o     (drop_cnt_r)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Records the pops that the coming edge will perform, then advances one cycle.
   task automatic tick();
      if (rd_valid && rd_ready) got_l.push_back(rd_data);
      if (rd_valid_r && rd_ready) begin
         got_r.push_back(rd_data_r);
         cyc_r.push_back(cyc);
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1; clear = 1'b0; sample_valid = 1'b0; rd_ready = 1'b0;
      left = '0; right = '0;
      tick();
      rst = 1'b0;
      got_l.delete(); got_r.delete(); cyc_r.delete();
   endtask

   task automatic check_seq(input string tag, input int base, input int n);
      check({tag, "_count"}, got_l.size(), n);
      for (int i = 0; i < n; i++)
         check(tag, (i < got_l.size()) ? {8'h0, got_l[i]} : 32'hDEAD_BEEF, base + i);
   endtask

   initial begin
      // Reset state
      do_reset();
      check("rst_fill", fill, 0);
      check("rst_valid", rd_valid, 0);
      check("rst_data", rd_data, 0);
      check("rst_bready", buffer_ready, 0);
      check("rst_ovf", overflow, 0);
      check("rst_fill_r", fill_r, 0);

      // First-word latency and stability with rd_ready low
      sample_valid = 1'b1; left = 24'h000010; tick();
      check("t1_valid_n", rd_valid, 0);
      left = 24'h000011; tick();
      check("t1_valid_n1", rd_valid, 0);
      left = 24'h000012; tick();
      check("t1_valid_n2", rd_valid, 1);
      check("t1_data_n2", rd_data, 24'h000010);
      check("t1_fill", fill, 3);
      sample_valid = 1'b0;
      tick(); tick(); tick();
      check("t1_data_hold", rd_data, 24'h000010);
      check("t1_valid_hold", rd_valid, 1);
      check("t1_fill_hold", fill, 3);
      check("t1_bready", buffer_ready, 0);

      // Right channel, streaming with rd_ready held high
      do_reset();
      rd_ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         sample_valid = (c < 5);
         right = 24'(-5 + c);
         tick();
      end
      check("t2_count", got_r.size(), 5);
      for (int i = 0; i < 5; i++) begin
         check("t2_data", (i < got_r.size()) ? {8'h0, got_r[i]} : 32'hDEAD_BEEF, 32'h00FF_FFFB + i);
         check("t2_cycle", (i < cyc_r.size()) ? cyc_r[i] : -1,
               (cyc_r.size() > 0) ? cyc_r[0] + i : -2);
      end
      check("t2_fill", fill_r, 0);

      // Threshold hysteresis
      do_reset();
      sample_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         left = 24'h100 + 24'(i);
         tick();
         if (i == 2) check("t3_bready_3", buffer_ready, 0);
      end
      check("t3_bready_4", buffer_ready, 1);
      check("t3_fill_4", fill, 4);
      sample_valid = 1'b0; rd_ready = 1'b1;
      tick(); tick(); tick();
      check("t3_fill_1", fill, 1);
      check("t3_bready_1", buffer_ready, 1);
      tick();
      rd_ready = 1'b0;
      check("t3_fill_0", fill, 0);
      check("t3_bready_0", buffer_ready, 0);
      check_seq("t3_data", 24'h100, 4);

      // Overflow on pushes into a full buffer
      do_reset();
      sample_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         left = 24'h200 + 24'(i);
         tick();
         if (i == 7) check("t4_ovf_at8", overflow, 0);
      end
      sample_valid = 1'b0;
      check("t4_fill", fill, 8);
      check("t4_ovf", overflow, 1);
`ifdef SAMPLE_RAM_BUFFER_DROP_CNT_EN
      check("t4_drop_cnt", drop_cnt, 2);
`endif
      rd_ready = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      rd_ready = 1'b0;
      check_seq("t4_data", 24'h200, 8);
      check("t4_ovf_sticky", overflow, 1);
      check("t4_fill_0", fill, 0);

      // Push and pop together while full, then pointer wrap
      do_reset();
      sample_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         left = 24'h300 + 24'(i);
         tick();
      end
      sample_valid = 1'b0;
      tick(); tick();
      check("t5_full", fill, 8);
      sample_valid = 1'b1; left = 24'h3FF; rd_ready = 1'b1;
      tick();
      sample_valid = 1'b0;
      check("t5_fill_pp", fill, 8);
      check("t5_ovf_pp", overflow, 0);
      for (int i = 0; i < 12; i++) tick();
      check("t5_count", got_l.size(), 9);
      for (int i = 0; i < 8; i++)
         check("t5_data", (i < got_l.size()) ? {8'h0, got_l[i]} : 32'hDEAD_BEEF, 32'h300 + i);
      check("t5_last", (got_l.size() > 8) ? {8'h0, got_l[8]} : 32'hDEAD_BEEF, 32'h3FF);
      got_l.delete();
      for (int c = 0; c < 30; c++) begin
         sample_valid = (c < 20);
         left = 24'h400 + 24'(c);
         tick();
      end
      rd_ready = 1'b0;
      check_seq("t5_wrap", 24'h400, 20);
      check("t5_wrap_fill", fill, 0);

      // Clear while holding data, with a simultaneous push
      do_reset();
      sample_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         left = 24'h500 + 24'(i);
         tick();
      end
      sample_valid = 1'b0; rd_ready = 1'b1;
      tick(); tick(); tick();
      rd_ready = 1'b0;
      check("t6_fill5", fill, 5);
      check("t6_valid1", rd_valid, 1);
      check("t6_ovf1", overflow, 1);
      check("t6_bready1", buffer_ready, 1);
`ifdef SAMPLE_RAM_BUFFER_DROP_CNT_EN
      check("t6_drop_cnt1", drop_cnt, 1);
`endif
      clear = 1'b1; sample_valid = 1'b1; left = 24'h5AA;
      tick();
      clear = 1'b0; sample_valid = 1'b0;
      check("t6_fill", fill, 0);
      check("t6_valid", rd_valid, 0);
      check("t6_bready", buffer_ready, 0);
      check("t6_ovf", overflow, 0);
`ifdef SAMPLE_RAM_BUFFER_DROP_CNT_EN
      check("t6_drop_cnt", drop_cnt, 0);
`endif
      tick(); tick(); tick();
      check("t6_valid_later", rd_valid, 0);
      check("t6_fill_later", fill, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
